// File: rtl/i2c_slave_rx.sv
// Write-only I2C slave receiver: address match, ACK generation, byte strobes.
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-tap agreement filter on scl/sda.
module i2c_slave_rx #(
  parameter logic [6:0] DEV_ADDR = 7'h27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_first,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    DATA,
    DATA_ACK,
    IGNORE
  } state_t;

  state_t              state;
  logic [1:0]          scl_sync;
  logic [1:0]          sda_sync;
  logic                scl_f;
  logic                sda_f;
  logic                scl_d;
  logic                sda_d;
  logic [BYTE_W-1:0]   shift;
  logic [CNT_W-1:0]    bit_cnt;
  logic                byte_done;
  logic                first_pend;
  logic                scl_rise;
  logic                scl_fall;
  logic                start_ev;
  logic                stop_ev;

  // Line pipeline is deliberately left out of reset so a mid-frame reset
  // cannot fabricate START/STOP edges from stale register values.
  always_ff @(posedge clk) begin
    scl_sync <= {scl_sync[0], scl_i};
    sda_sync <= {sda_sync[0], sda_i};
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_tap;
  logic [1:0] sda_tap;
  logic       scl_q;
  logic       sda_q;

  // Filtered level only moves when the newest sample and both taps agree.
  always_comb begin
    scl_f = scl_q;
    sda_f = sda_q;
    if (scl_sync[1] && (&scl_tap))
      scl_f = 1'b1;
    else if (!scl_sync[1] && !(|scl_tap))
      scl_f = 1'b0;
    if (sda_sync[1] && (&sda_tap))
      sda_f = 1'b1;
    else if (!sda_sync[1] && !(|sda_tap))
      sda_f = 1'b0;
  end

  always_ff @(posedge clk) begin
    scl_tap <= {scl_tap[0], scl_sync[1]};
    sda_tap <= {sda_tap[0], sda_sync[1]};
    scl_q   <= scl_f;
    sda_q   <= sda_f;
  end
`else
  assign scl_f = scl_sync[1];
  assign sda_f = sda_sync[1];
`endif

  always_ff @(posedge clk) begin
    scl_d <= scl_f;
    sda_d <= sda_f;
  end

  // Bus events require scl high on both sides of the sda transition.
  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shift      <= '0;
      bit_cnt    <= '0;
      byte_done  <= 1'b0;
      first_pend <= 1'b0;
      sda_oe     <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_first   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_first <= 1'b0;
      if (start_ev) begin
        state     <= ADDR;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_ev) begin
        state     <= IDLE;
        bit_cnt   <= '0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state)
          ADDR: begin
            if (scl_rise) begin
              shift   <= {shift[BYTE_W-2:0], sda_f};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7))
                byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (shift[7:1] == DEV_ADDR && !shift[0]) begin
                state      <= ADDR_ACK;
                sda_oe     <= 1'b1;
                busy       <= 1'b1;
                first_pend <= 1'b1;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
          end
          DATA: begin
            if (scl_rise) begin
              shift   <= {shift[BYTE_W-2:0], sda_f};
              bit_cnt <= bit_cnt + CNT_W'(1);
              if (bit_cnt == CNT_W'(7))
                byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done  <= 1'b0;
              rx_data    <= shift;
              rx_valid   <= 1'b1;
              rx_first   <= first_pend;
              first_pend <= 1'b0;
              sda_oe     <= 1'b1;
              state      <= DATA_ACK;
            end
          end
          ADDR_ACK, DATA_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              state  <= DATA;
            end
          end
          default: begin
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Directed bench for i2c_slave_rx: bit-banged master on an open-drain SDA model.
module tb_i2c_slave_rx;

  localparam int unsigned H = 16;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam logic [7:0] GLITCH_EXP = 8'h7F;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h3F;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       m_scl;
  logic       m_sda;
  logic       sda_bus;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_first;
  logic       busy;

  int errors = 0;
  int checks = 0;
  int n_strobe = 0;
  int oe_cycles = 0;
  logic [7:0] cap_data [0:15];
  logic       cap_first[0:15];

  assign sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_rx dut (
    .clk      (clk),
    .rst      (rst),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_first (rx_first),
    .busy     (busy)
  );

  always @(posedge clk) begin
    if (rx_valid) begin
      if (n_strobe < 16) begin
        cap_data[n_strobe[3:0]]  <= rx_data;
        cap_first[n_strobe[3:0]] <= rx_first;
      end
      n_strobe <= n_strobe + 1;
    end
    if (sda_oe)
      oe_cycles <= oe_cycles + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic start_cond();
    m_scl = 1'b0;
    wait_clk(H / 2);
    m_sda = 1'b1;
    wait_clk(H / 2);
    m_scl = 1'b1;
    wait_clk(H);
    m_sda = 1'b0;
    wait_clk(H);
    m_scl = 1'b0;
  endtask

  task automatic stop_cond();
    wait_clk(H / 2);
    m_sda = 1'b0;
    wait_clk(H / 2);
    m_scl = 1'b1;
    wait_clk(H);
    m_sda = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    wait_clk(H / 2);
    m_sda = b;
    wait_clk(H / 2);
    m_scl = 1'b1;
    wait_clk(H);
    m_scl = 1'b0;
  endtask

  // Optional 1-clk scl glitch right after the MSB, while sda still holds it.
  task automatic send_byte(input logic [7:0] d, input logic glitch, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (glitch && i == 6) begin
        wait_clk(2);
        m_scl = 1'b1;
        wait_clk(1);
        m_scl = 1'b0;
      end
      send_bit(d[i]);
    end
    wait_clk(H / 2);
    m_sda = 1'b1;
    wait_clk(H / 2);
    m_scl = 1'b1;
    wait_clk(H / 2);
    ack = ~sda_bus;
    wait_clk(H / 2);
    m_scl = 1'b0;
  endtask

  initial begin
    logic ack;
    int   s0;
    int   o0;

    rst   = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(6);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'h00);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_first", 32'(rx_first), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    o0 = oe_cycles;
    wait_clk(1000);
    chk("idle_oe_cycles", 32'(oe_cycles - o0), 32'd0);

    // Single byte write
    s0 = n_strobe;
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("a_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h7F, 1'b0, ack);
    chk("a_data_ack", 32'(ack), 32'd1);
    chk("a_busy_in_frame", 32'(busy), 32'd1);
    stop_cond();
    wait_clk(4);
    chk("a_busy_after_stop", 32'(busy), 32'd0);
    chk("a_strobes", 32'(n_strobe - s0), 32'd1);
    chk("a_data", 32'(cap_data[s0]), 32'h7F);
    chk("a_first", 32'(cap_first[s0]), 32'd1);

    // Three byte write
    s0 = n_strobe;
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("b_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h12, 1'b0, ack);
    chk("b_ack0", 32'(ack), 32'd1);
    send_byte(8'h34, 1'b0, ack);
    chk("b_ack1", 32'(ack), 32'd1);
    send_byte(8'h56, 1'b0, ack);
    chk("b_ack2", 32'(ack), 32'd1);
    stop_cond();
    wait_clk(4);
    chk("b_strobes", 32'(n_strobe - s0), 32'd3);
    chk("b_data0", 32'(cap_data[s0]), 32'h12);
    chk("b_data1", 32'(cap_data[s0 + 1]), 32'h34);
    chk("b_data2", 32'(cap_data[s0 + 2]), 32'h56);
    chk("b_first0", 32'(cap_first[s0]), 32'd1);
    chk("b_first1", 32'(cap_first[s0 + 1]), 32'd0);
    chk("b_first2", 32'(cap_first[s0 + 2]), 32'd0);

    // Wrong address, then a data byte that must not be acknowledged
    s0 = n_strobe;
    o0 = oe_cycles;
    start_cond();
    send_byte(8'h50, 1'b0, ack);
    chk("c_wrong_addr_ack", 32'(ack), 32'd0);
    chk("c_busy", 32'(busy), 32'd0);
    send_byte(8'h7F, 1'b0, ack);
    chk("c_data_ack", 32'(ack), 32'd0);
    stop_cond();
    // Read request is unsupported
    start_cond();
    send_byte(8'h4F, 1'b0, ack);
    chk("c_read_ack", 32'(ack), 32'd0);
    chk("c_read_busy", 32'(busy), 32'd0);
    stop_cond();
    wait_clk(4);
    chk("c_strobes", 32'(n_strobe - s0), 32'd0);
    chk("c_oe_cycles", 32'(oe_cycles - o0), 32'd0);

    // Partial byte aborted by repeated START
    s0 = n_strobe;
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("d_addr_ack", 32'(ack), 32'd1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("d_readdr_ack", 32'(ack), 32'd1);
    send_byte(8'hA5, 1'b0, ack);
    chk("d_data_ack", 32'(ack), 32'd1);
    chk("d_busy", 32'(busy), 32'd1);
    stop_cond();
    wait_clk(4);
    chk("d_strobes", 32'(n_strobe - s0), 32'd1);
    chk("d_data", 32'(cap_data[s0]), 32'hA5);
    chk("d_first", 32'(cap_first[s0]), 32'd1);

    // Reset inside the address ACK slot
    s0 = n_strobe;
    start_cond();
    for (int i = 7; i >= 0; i--) begin
      logic [7:0] a;
      a = 8'h4E;
      send_bit(a[i]);
    end
    wait_clk(H / 2);
    chk("e_ack_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    wait_clk(1);
    chk("e_oe_after_rst", 32'(sda_oe), 32'd0);
    rst = 1'b0;
    m_sda = 1'b1;
    wait_clk(H / 2);
    m_scl = 1'b1;
    wait_clk(H);
    m_scl = 1'b0;
    send_byte(8'h11, 1'b0, ack);
    chk("e_tail_ack", 32'(ack), 32'd0);
    stop_cond();
    wait_clk(4);
    chk("e_tail_strobes", 32'(n_strobe - s0), 32'd0);
    chk("e_busy", 32'(busy), 32'd0);
    s0 = n_strobe;
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("e_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h3C, 1'b0, ack);
    chk("e_data_ack", 32'(ack), 32'd1);
    stop_cond();
    wait_clk(4);
    chk("e_strobes", 32'(n_strobe - s0), 32'd1);
    chk("e_data", 32'(cap_data[s0]), 32'h3C);
    chk("e_first", 32'(cap_first[s0]), 32'd1);

    // One-clk scl glitch after the MSB of 0x7F
    s0 = n_strobe;
    start_cond();
    send_byte(8'h4E, 1'b0, ack);
    chk("f_addr_ack", 32'(ack), 32'd1);
    send_byte(8'h7F, 1'b1, ack);
    stop_cond();
    wait_clk(4);
    chk("f_strobes", 32'(n_strobe - s0), 32'd1);
    chk("f_data", 32'(cap_data[s0]), 32'(GLITCH_EXP));
    chk("f_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
